// File: rtl/tap_pkg.sv
// Shared constants for the JTAG IR/DR datapath: TAP state codes, default
// opcodes, the IDCODE register width and the DR-select type.
package tap_pkg;

   // TAP controller state codes as observed on state_obs3..0
   localparam logic [3:0] ST_TLR      = 4'b0000;
   localparam logic [3:0] ST_RTI      = 4'b0001;
   localparam logic [3:0] ST_SEL_DR   = 4'b0010;
   localparam logic [3:0] ST_CAP_DR   = 4'b0011;
   localparam logic [3:0] ST_SH_DR    = 4'b0100;
   localparam logic [3:0] ST_EX1_DR   = 4'b0101;
   localparam logic [3:0] ST_PAUSE_DR = 4'b0110;
   localparam logic [3:0] ST_EX2_DR   = 4'b0111;
   localparam logic [3:0] ST_UPD_DR   = 4'b1000;
   localparam logic [3:0] ST_SEL_IR   = 4'b1001;
   localparam logic [3:0] ST_CAP_IR   = 4'b1010;
   localparam logic [3:0] ST_SH_IR    = 4'b1011;
   localparam logic [3:0] ST_EX1_IR   = 4'b1100;
   localparam logic [3:0] ST_PAUSE_IR = 4'b1101;
   localparam logic [3:0] ST_EX2_IR   = 4'b1110;
   localparam logic [3:0] ST_UPD_IR   = 4'b1111;

   // Default opcodes for a 4-bit instruction register
   localparam logic [3:0] INSN_BYPASS_DEF = 4'b1111;
   localparam logic [3:0] INSN_IDCODE_DEF = 4'b0001;
   localparam logic [3:0] INSN_USER_DEF   = 4'b1000;

   // Width of the IDCODE data register
   localparam int IDCODE_W = 32;

   // Which data register sits between TDI and TDO
   typedef enum logic [1:0] {
      DR_BYPASS = 2'd0,
      DR_IDCODE = 2'd1,
      DR_USER   = 2'd2
   } dr_sel_e;

endpackage

// File: rtl/tap_ir_dr_path_if.sv
// Strobe interface between the TAP datapath and one external user data
// register. The datapath is the master; the user DR is the slave.
interface tap_ir_dr_path_if;

   logic user_sel;
   logic user_capture;
   logic user_shift;
   logic user_update;
   logic user_tdo;

   modport master (
      output user_sel,
      output user_capture,
      output user_shift,
      output user_update,
      input  user_tdo
   );

   modport slave (
      input  user_sel,
      input  user_capture,
      input  user_shift,
      input  user_update,
      output user_tdo
   );

endinterface

// File: rtl/tap_ir_reg.sv
// JTAG instruction register: capture of the fixed "..01" pattern, serial
// shift from TDI, parallel update into ir_out, and reload of IDCODE on
// reset or Test-Logic-Reset.
module tap_ir_reg
   import tap_pkg::*;
#(
   parameter int               IR_W        = 4,
   parameter logic [IR_W-1:0]  INSN_IDCODE = IR_W'(INSN_IDCODE_DEF)
)(
   input  logic            clk,
   input  logic            TRST_n,
   input  logic [3:0]      tap_state,
   input  logic            TDI,
   output logic [IR_W-1:0] ir_out,
   output logic            ir_tdo
);

   localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(1);

   logic [IR_W-1:0] ir_shift;

   // Shift stage captures/shifts; the instruction only changes on UpdIR or TLR
   always_ff @(posedge clk or negedge TRST_n) begin
      if (!TRST_n) begin
         ir_out   <= INSN_IDCODE;
         ir_shift <= IR_CAPTURE;
      end else begin
         case (tap_state)
            ST_TLR:    ir_out   <= INSN_IDCODE;
            ST_CAP_IR: ir_shift <= IR_CAPTURE;
            ST_SH_IR:  ir_shift <= {TDI, ir_shift[IR_W-1:1]};
            ST_UPD_IR: ir_out   <= ir_shift;
            default:   ;
         endcase
      end
   end

   assign ir_tdo = ir_shift[0];

endmodule

// File: rtl/tap_ir_dr_path.sv
// JTAG IR/DR datapath downstream of the TAP state controller: instruction
// register, BYPASS and IDCODE data registers, TDO mux and the strobes for
// one external user DR.
// Optional feature macro TAP_DR_SHIFT_CNT_EN adds a saturating count of
// ShDR cycles since the last CapDR on output dr_shift_cnt.
module tap_ir_dr_path
   import tap_pkg::*;
#(
   parameter int                  IR_W        = 4,
   parameter logic [IDCODE_W-1:0] IDCODE_VAL  = 32'h1000_0001,
   parameter logic [IR_W-1:0]     INSN_IDCODE = IR_W'(INSN_IDCODE_DEF),
   parameter logic [IR_W-1:0]     INSN_USER   = IR_W'(INSN_USER_DEF)
)(
   input  logic            clk,
   input  logic            TRST_n,
   input  logic [3:0]      tap_state,
   input  logic            TDI,
   output logic            TDO,
   output logic            tdo_en,
   output logic [IR_W-1:0] ir_out,
`ifdef TAP_DR_SHIFT_CNT_EN
   output logic [15:0]     dr_shift_cnt,
`endif
   tap_ir_dr_path_if.master user_dr
);

   logic                ir_tdo;
   logic                bypass_ff;
   logic [IDCODE_W-1:0] id_shift;
   dr_sel_e             dr_sel;

   tap_ir_reg #(
      .IR_W        (IR_W),
      .INSN_IDCODE (INSN_IDCODE)
   ) u_ir_reg (
      .clk       (clk),
      .TRST_n    (TRST_n),
      .tap_state (tap_state),
      .TDI       (TDI),
      .ir_out    (ir_out),
      .ir_tdo    (ir_tdo)
   );

   // DR path chosen from the updated instruction only, so an IR scan in flight cannot redirect it
   always_comb begin
      dr_sel = DR_BYPASS;
      if (ir_out == INSN_IDCODE)
         dr_sel = DR_IDCODE;
      else if (ir_out == INSN_USER)
         dr_sel = DR_USER;
   end

   // BYPASS and IDCODE registers capture in CapDR and shift in ShDR; the user DR lives outside
   always_ff @(posedge clk or negedge TRST_n) begin
      if (!TRST_n) begin
         bypass_ff <= 1'b0;
         id_shift  <= '0;
      end else begin
         case (tap_state)
            ST_CAP_DR: begin
               if (dr_sel == DR_IDCODE)
                  id_shift <= IDCODE_VAL;
               else if (dr_sel == DR_BYPASS)
                  bypass_ff <= 1'b0;
            end
            ST_SH_DR: begin
               if (dr_sel == DR_IDCODE)
                  id_shift <= {TDI, id_shift[IDCODE_W-1:1]};
               else if (dr_sel == DR_BYPASS)
                  bypass_ff <= TDI;
            end
            default: ;
         endcase
      end
   end

`ifdef TAP_DR_SHIFT_CNT_EN
   // Saturating count of ShDR cycles since the last CapDR
   always_ff @(posedge clk or negedge TRST_n) begin
      if (!TRST_n)
         dr_shift_cnt <= '0;
      else if (tap_state == ST_CAP_DR)
         dr_shift_cnt <= '0;
      else if (tap_state == ST_SH_DR && dr_shift_cnt != 16'hFFFF)
         dr_shift_cnt <= dr_shift_cnt + 16'd1;
   end
`endif

   // TDO is driven only while shifting; anything else (including unknown codes) keeps it quiet
   always_comb begin
      TDO    = 1'b0;
      tdo_en = 1'b0;
      case (tap_state)
         ST_SH_IR: begin
            TDO    = ir_tdo;
            tdo_en = 1'b1;
         end
         ST_SH_DR: begin
            tdo_en = 1'b1;
            case (dr_sel)
               DR_IDCODE: TDO = id_shift[0];
               DR_USER:   TDO = user_dr.user_tdo;
               default:   TDO = bypass_ff;
            endcase
         end
         default: ;
      endcase
   end

   // User DR strobes follow the TAP state directly, gated by the USER instruction
   always_comb begin
      user_dr.user_sel     = (ir_out == INSN_USER);
      user_dr.user_capture = user_dr.user_sel && (tap_state == ST_CAP_DR);
      user_dr.user_shift   = user_dr.user_sel && (tap_state == ST_SH_DR);
      user_dr.user_update  = user_dr.user_sel && (tap_state == ST_UPD_DR);
   end

endmodule

// File: tb/tb_tap_ir_dr_path.sv
// Self-checking bench for tap_ir_dr_path: a driver issues one TAP state per
// cycle and pushes the expected outputs (from a queue-based reference model)
// into a scoreboard; a monitor pops and compares on the falling edge.
module tb_tap_ir_dr_path;

   localparam logic [31:0] ID_VAL  = 32'h1000_0001;
   localparam logic [3:0]  OP_ID   = 4'b0001;
   localparam logic [3:0]  OP_USER = 4'b1000;

   localparam logic [3:0] TLR = 4'h0, RTI = 4'h1, SELDR = 4'h2, CAPDR = 4'h3,
                          SHDR = 4'h4, EX1DR = 4'h5, UPDDR = 4'h8,
                          SELIR = 4'h9, CAPIR = 4'hA, SHIR = 4'hB,
                          EX1IR = 4'hC, UPDIR = 4'hF;

   typedef struct packed {
      logic        tdo;
      logic        tdo_en;
      logic [3:0]  ir;
      logic        sel;
      logic        cap;
      logic        sh;
      logic        upd;
      logic [15:0] cnt;
   } exp_t;

   logic       clk = 1'b0;
   logic       TRST_n = 1'b0;
   logic [3:0] tap_state = TLR;
   logic       TDI = 1'b0;
   logic       TDO;
   logic       tdo_en;
   logic [3:0] ir_out;
`ifdef TAP_DR_SHIFT_CNT_EN
   logic [15:0] dr_shift_cnt;
`endif

   tap_ir_dr_path_if user_dr_if();

   tap_ir_dr_path dut (
      .clk       (clk),
      .TRST_n    (TRST_n),
      .tap_state (tap_state),
      .TDI       (TDI),
      .TDO       (TDO),
      .tdo_en    (tdo_en),
      .ir_out    (ir_out),
`ifdef TAP_DR_SHIFT_CNT_EN
      .dr_shift_cnt (dr_shift_cnt),
`endif
      .user_dr   (user_dr_if.master)
   );

   always #5 clk = ~clk;

   int   assert_count = 0;
   int   fail_count   = 0;
   exp_t exp_q[$];
   logic stim_valid = 1'b0;
   logic collect_on = 1'b0;
   logic [31:0] id_seen = '0;
   int   id_bits = 0;

   // Reference model: shift registers as bit queues, front = bit nearest TDO
   logic [3:0] m_ir;
   bit         m_irq[$];
   bit         m_idq[$];
   bit         m_byp;
   int         m_cnt;

   function automatic void model_reset();
      m_ir  = OP_ID;
      m_irq = '{1'b1, 1'b0, 1'b0, 1'b0};
      m_idq = {};
      for (int i = 0; i < 32; i++) m_idq.push_back(1'b0);
      m_byp = 1'b0;
      m_cnt = 0;
   endfunction

   function automatic int dr_kind();
      if (m_ir == OP_ID) return 1;
      if (m_ir == OP_USER) return 2;
      return 0;
   endfunction

   function automatic exp_t model_outputs(input logic [3:0] st, input logic utdo);
      exp_t e;
      e        = '0;
      e.ir     = m_ir;
      e.sel    = (m_ir == OP_USER);
      e.cap    = e.sel && (st == CAPDR);
      e.sh     = e.sel && (st == SHDR);
      e.upd    = e.sel && (st == UPDDR);
      e.cnt    = 16'(m_cnt);
      if (st == SHIR) begin
         e.tdo_en = 1'b1;
         e.tdo    = m_irq[0];
      end else if (st == SHDR) begin
         e.tdo_en = 1'b1;
         case (dr_kind())
            1:       e.tdo = m_idq[0];
            2:       e.tdo = utdo;
            default: e.tdo = m_byp;
         endcase
      end
      return e;
   endfunction

   function automatic void model_advance(input logic [3:0] st, input logic tdi);
      case (st)
         TLR:   m_ir = OP_ID;
         CAPIR: m_irq = '{1'b1, 1'b0, 1'b0, 1'b0};
         SHIR:  begin void'(m_irq.pop_front()); m_irq.push_back(tdi); end
         UPDIR: for (int i = 0; i < 4; i++) m_ir[i] = m_irq[i];
         CAPDR: begin
            m_cnt = 0;
            if (dr_kind() == 1) begin
               m_idq = {};
               for (int i = 0; i < 32; i++) m_idq.push_back(ID_VAL[i]);
            end else if (dr_kind() == 0) m_byp = 1'b0;
         end
         SHDR: begin
            if (m_cnt < 65535) m_cnt++;
            if (dr_kind() == 1) begin void'(m_idq.pop_front()); m_idq.push_back(tdi); end
            else if (dr_kind() == 0) m_byp = tdi;
         end
         default: ;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      assert_count++;
      if (act !== exp) begin
         fail_count++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One TAP cycle: drive inputs after the rising edge, record expectation, advance model
   task automatic applyStimulus(input logic [3:0] st, input logic tdi, input logic utdo, input logic rst);
      @(posedge clk);
      #1;
      TRST_n           = !rst;
      tap_state        = st;
      TDI              = tdi;
      user_dr_if.user_tdo = utdo;
      if (rst) model_reset();
      exp_q.push_back(model_outputs(st, utdo));
      stim_valid = 1'b1;
      if (!rst) model_advance(st, tdi);
   endtask

   task automatic load_ir(input logic [3:0] op);
      applyStimulus(SELDR, 1'b0, 1'b0, 1'b0);
      applyStimulus(SELIR, 1'b0, 1'b0, 1'b0);
      applyStimulus(CAPIR, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(SHIR, op[i], 1'b0, 1'b0);
      applyStimulus(EX1IR, 1'b0, 1'b0, 1'b0);
      applyStimulus(UPDIR, 1'b0, 1'b0, 1'b0);
      applyStimulus(RTI, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic scan_dr(input int n, input logic [31:0] pattern, input logic utdo);
      applyStimulus(SELDR, 1'b0, utdo, 1'b0);
      applyStimulus(CAPDR, 1'b0, utdo, 1'b0);
      for (int i = 0; i < n; i++) applyStimulus(SHDR, pattern[i % 32], utdo, 1'b0);
      applyStimulus(EX1DR, 1'b0, utdo, 1'b0);
      applyStimulus(UPDDR, 1'b0, utdo, 1'b0);
      applyStimulus(RTI, 1'b0, utdo, 1'b0);
   endtask

   // Monitor: every driven cycle presents one response, compared mid-cycle
   always @(negedge clk) begin
      if (stim_valid) begin
         if (exp_q.size() == 0) begin
            checkOutput("scoreboard_underflow", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput("tdo",          32'(TDO),                     32'(e.tdo));
            checkOutput("tdo_en",       32'(tdo_en),                  32'(e.tdo_en));
            checkOutput("ir_out",       32'(ir_out),                  32'(e.ir));
            checkOutput("user_sel",     32'(user_dr_if.user_sel),     32'(e.sel));
            checkOutput("user_capture", 32'(user_dr_if.user_capture), 32'(e.cap));
            checkOutput("user_shift",   32'(user_dr_if.user_shift),   32'(e.sh));
            checkOutput("user_update",  32'(user_dr_if.user_update),  32'(e.upd));
`ifdef TAP_DR_SHIFT_CNT_EN
            checkOutput("dr_shift_cnt", 32'(dr_shift_cnt),            32'(e.cnt));
`endif
         end
         if (collect_on && tdo_en) begin
            id_seen = {TDO, id_seen[31:1]};
            id_bits++;
         end
      end
   end

   initial begin
      logic [31:0] pat;
      user_dr_if.user_tdo = 1'b0;
      model_reset();

      // Reset, then IDCODE readout with an explicit LSB-first collection
      applyStimulus(TLR, 1'b0, 1'b0, 1'b1);
      applyStimulus(TLR, 1'b0, 1'b0, 1'b1);
      applyStimulus(TLR, 1'b0, 1'b0, 1'b0);
      applyStimulus(RTI, 1'b0, 1'b0, 1'b0);
      applyStimulus(SELDR, 1'b0, 1'b0, 1'b0);
      applyStimulus(CAPDR, 1'b0, 1'b0, 1'b0);
      collect_on = 1'b1;
      for (int i = 0; i < 32; i++) applyStimulus(SHDR, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      applyStimulus(EX1DR, 1'b0, 1'b0, 1'b0);
      collect_on = 1'b0;
      checkOutput("idcode_readout", id_seen, ID_VAL);
      checkOutput("idcode_bits", 32'(id_bits), 32'd32);
      applyStimulus(UPDDR, 1'b0, 1'b0, 1'b0);
      applyStimulus(RTI, 1'b0, 1'b0, 1'b0);

      // BYPASS via all-ones and via an unlisted opcode
      load_ir(4'b1111);
      pat = 32'b1101;
      scan_dr(4, pat, 1'b0);
      load_ir(4'b0101);
      scan_dr(4, pat, 1'b0);

      // USER path with the external DR returning ones
      load_ir(OP_USER);
      scan_dr(3, 32'h0, 1'b1);

      // Reset in the second ShIR cycle, then confirm IDCODE is back
      applyStimulus(SELDR, 1'b0, 1'b0, 1'b0);
      applyStimulus(SELIR, 1'b0, 1'b0, 1'b0);
      applyStimulus(CAPIR, 1'b0, 1'b0, 1'b0);
      applyStimulus(SHIR, 1'b1, 1'b0, 1'b0);
      applyStimulus(TLR, 1'b1, 1'b0, 1'b1);
      applyStimulus(TLR, 1'b0, 1'b0, 1'b0);
      applyStimulus(RTI, 1'b0, 1'b0, 1'b0);
      scan_dr(32, $urandom, 1'b0);

      // Long DR scan, then a fresh capture
      scan_dr(40, $urandom, 1'b0);
      applyStimulus(SELDR, 1'b0, 1'b0, 1'b0);
      applyStimulus(CAPDR, 1'b0, 1'b0, 1'b0);
      applyStimulus(EX1DR, 1'b0, 1'b0, 1'b0);

      // Random state walk with occasional resets
      for (int i = 0; i < 600; i++)
         applyStimulus(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));

      @(posedge clk);
      #1;
      stim_valid = 1'b0;
      checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
